// File: rtl/cajero_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : cajero_pkg
//  Description : Shared definitions for the cajero_param ATM controller:
//                one-hot state encoding and transaction-type constants.
//  Revision    : 1.0 - initial release
// ============================================================================
package cajero_pkg;

    // One-hot controller states, IDLE in bit 0 upward.
    typedef enum logic [5:0] {
        IDLE            = 6'b000001,
        RECIBIENDO_PIN  = 6'b000010,
        COMPARAR_PIN    = 6'b000100,
        ESPERANDO_MONTO = 6'b001000,
        TRANSACCION     = 6'b010000,
        BLOQUEO         = 6'b100000
    } estado_t;

    // Encoding of tipo_trans.
    localparam logic DEPOSITO = 1'b0;
    localparam logic RETIRO   = 1'b1;

endpackage
`default_nettype wire

// File: rtl/cajero_param_if.sv
`default_nettype none
// ============================================================================
//  Module      : cajero_param_if
//  Description : Front-end bus of the ATM controller. Carries the card,
//                keypad and amount inputs plus the dispenser/status outputs.
//                master = front-end / account store, slave = controller.
//  Ports       : tarjeta_recibida, balance_entrada, pin, digito_stb, digito,
//                tipo_trans, monto_stb, monto (master -> slave);
//                balance_actualizado, entregar_dinero, pin_incorrecto,
//                advertencia, bloqueo, fondos_insuficientes (slave -> master)
//  Revision    : 1.0 - initial release
// ============================================================================
interface cajero_param_if #(
    parameter int N_DIGITOS     = 4,
    parameter int ANCHO_BALANCE = 32,
    parameter int ANCHO_MONTO   = 32
);
    logic                       tarjeta_recibida;
    logic [ANCHO_BALANCE-1:0]   balance_entrada;
    logic [4*N_DIGITOS-1:0]     pin;
    logic                       digito_stb;
    logic [3:0]                 digito;
    logic                       tipo_trans;
    logic                       monto_stb;
    logic [ANCHO_MONTO-1:0]     monto;

    logic [ANCHO_BALANCE-1:0]   balance_actualizado;
    logic                       entregar_dinero;
    logic                       pin_incorrecto;
    logic                       advertencia;
    logic                       bloqueo;
    logic                       fondos_insuficientes;

    modport master (
        output tarjeta_recibida, balance_entrada, pin, digito_stb, digito,
               tipo_trans, monto_stb, monto,
        input  balance_actualizado, entregar_dinero, pin_incorrecto,
               advertencia, bloqueo, fondos_insuficientes
    );

    modport slave (
        input  tarjeta_recibida, balance_entrada, pin, digito_stb, digito,
               tipo_trans, monto_stb, monto,
        output balance_actualizado, entregar_dinero, pin_incorrecto,
               advertencia, bloqueo, fondos_insuficientes
    );
endinterface
`default_nettype wire

// File: rtl/cajero_pin_registro.sv
`default_nettype none
// ============================================================================
//  Module      : cajero_pin_registro
//  Description : PIN entry register. Shifts keypad digits in at the LS
//                nibble and counts them.
//  Ports       : clock, reset      - clock, synchronous active-high reset
//                limpiar           - clear the digit counter
//                desplazar, digito - shift one digit in
//                completo          - this shift delivers the last digit
//                pin_ingresado     - digits collected so far, first in MS
//  Revision    : 1.0 - initial release
// ============================================================================
module cajero_pin_registro #(
    parameter int N_DIGITOS = 4
) (
    input  wire logic                   clock,
    input  wire logic                   reset,
    input  wire logic                   limpiar,
    input  wire logic                   desplazar,
    input  wire logic [3:0]             digito,
    output logic                        completo,
    output logic [4*N_DIGITOS-1:0]      pin_ingresado
);
    localparam int ANCHO_PIN = 4 * N_DIGITOS;
    localparam int ANCHO_CNT = $clog2(N_DIGITOS + 1);

    logic [ANCHO_PIN-1:0] r_pin;
    logic [ANCHO_CNT-1:0] r_cuenta;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_pin    <= '0;
            r_cuenta <= '0;
        end else if (limpiar) begin
            r_cuenta <= '0;
        end else if (desplazar) begin
            r_pin    <= (r_pin << 4) | ANCHO_PIN'(digito);
            r_cuenta <= r_cuenta + ANCHO_CNT'(1);
        end
    end

    // Combinational so the controller can leave the entry state on the
    // same edge that captures the last digit.
    assign completo      = desplazar && (r_cuenta == ANCHO_CNT'(N_DIGITOS - 1));
    assign pin_ingresado = r_pin;

endmodule
`default_nettype wire

// File: rtl/cajero_param.sv
`default_nettype none
// ============================================================================
//  Module      : cajero_param
//  Description : Parametrised ATM transaction controller. Card in, N-digit
//                PIN check with retry limit / warning / sticky lockout, then
//                one deposit (saturating) or withdrawal (overdraft-checked).
//  Ports       : clock, reset - clock, synchronous active-high reset
//                bus          - cajero_param_if slave (card, keypad, amount,
//                               balance and status outputs)
//  Revision    : 1.0 - initial release
// ============================================================================
module cajero_param
    import cajero_pkg::*;
#(
    parameter int N_DIGITOS     = 4,
    parameter int MAX_INTENTOS  = 3,
    parameter int ANCHO_BALANCE = 32,
    parameter int ANCHO_MONTO   = 32
) (
    input  wire logic        clock,
    input  wire logic        reset,
    cajero_param_if.slave    bus
);
    localparam int ANCHO_INT = $clog2(MAX_INTENTOS + 1);

    estado_t                  r_estado, w_estado_sig;
    logic [ANCHO_BALANCE-1:0] r_balance, w_balance_sig;
    logic [ANCHO_MONTO-1:0]   r_monto, w_monto_sig;
    logic                     r_tipo, w_tipo_sig;
    logic [ANCHO_INT-1:0]     r_intentos, w_intentos_sig;
    logic                     r_adv, w_adv_sig;
    logic                     r_bloqueo, w_bloqueo_sig;
    logic                     r_entregar, w_entregar_sig;
    logic                     r_pin_inc, w_pin_inc_sig;
    logic                     r_fondos, w_fondos_sig;

    logic                     w_limpiar;
    logic                     w_desplazar;
    logic                     w_completo;
    logic [4*N_DIGITOS-1:0]   w_pin_ingresado;
    logic [ANCHO_INT-1:0]     w_intentos_inc;
    logic [ANCHO_BALANCE-1:0] w_monto_ext;
    logic [ANCHO_BALANCE:0]   w_suma;

    // Kept outside the FSM block so the completo path back from the
    // sub-module does not form a loop through one process.
    assign w_desplazar = (r_estado == RECIBIENDO_PIN) && bus.digito_stb;

    cajero_pin_registro #(
        .N_DIGITOS (N_DIGITOS)
    ) u_pin_registro (
        .clock         (clock),
        .reset         (reset),
        .limpiar       (w_limpiar),
        .desplazar     (w_desplazar),
        .digito        (bus.digito),
        .completo      (w_completo),
        .pin_ingresado (w_pin_ingresado)
    );

    assign w_intentos_inc = r_intentos + ANCHO_INT'(1);
    assign w_monto_ext    = ANCHO_BALANCE'(r_monto);
    // Extra carry bit detects deposit overflow for saturation.
    assign w_suma         = {1'b0, r_balance} + {1'b0, w_monto_ext};

    always_ff @(posedge clock) begin
        if (reset) begin
            r_estado   <= IDLE;
            r_balance  <= '0;
            r_monto    <= '0;
            r_tipo     <= DEPOSITO;
            r_intentos <= '0;
            r_adv      <= 1'b0;
            r_bloqueo  <= 1'b0;
            r_entregar <= 1'b0;
            r_pin_inc  <= 1'b0;
            r_fondos   <= 1'b0;
        end else begin
            r_estado   <= w_estado_sig;
            r_balance  <= w_balance_sig;
            r_monto    <= w_monto_sig;
            r_tipo     <= w_tipo_sig;
            r_intentos <= w_intentos_sig;
            r_adv      <= w_adv_sig;
            r_bloqueo  <= w_bloqueo_sig;
            r_entregar <= w_entregar_sig;
            r_pin_inc  <= w_pin_inc_sig;
            r_fondos   <= w_fondos_sig;
        end
    end

    always_comb begin
        w_estado_sig   = r_estado;
        w_balance_sig  = r_balance;
        w_monto_sig    = r_monto;
        w_tipo_sig     = r_tipo;
        w_intentos_sig = r_intentos;
        w_adv_sig      = r_adv;
        w_bloqueo_sig  = r_bloqueo;
        w_entregar_sig = 1'b0;
        w_pin_inc_sig  = 1'b0;
        w_fondos_sig   = 1'b0;
        w_limpiar      = 1'b0;

        case (r_estado)
            IDLE: begin
                if (bus.tarjeta_recibida) begin
                    w_balance_sig = bus.balance_entrada;
                    w_limpiar     = 1'b1;
                    w_estado_sig  = RECIBIENDO_PIN;
                end
            end
            RECIBIENDO_PIN: begin
                if (w_completo) begin
                    w_estado_sig = COMPARAR_PIN;
                end
            end
            COMPARAR_PIN: begin
                if (w_pin_ingresado == bus.pin) begin
                    w_intentos_sig = '0;
                    w_adv_sig      = 1'b0;
                    w_estado_sig   = ESPERANDO_MONTO;
                end else begin
                    w_intentos_sig = w_intentos_inc;
                    w_pin_inc_sig  = 1'b1;
                    if (w_intentos_inc == ANCHO_INT'(MAX_INTENTOS)) begin
                        w_bloqueo_sig = 1'b1;
                        w_estado_sig  = BLOQUEO;
                    end else begin
                        if (w_intentos_inc == ANCHO_INT'(MAX_INTENTOS - 1)) begin
                            w_adv_sig = 1'b1;
                        end
                        w_limpiar    = 1'b1;
                        w_estado_sig = RECIBIENDO_PIN;
                    end
                end
            end
            ESPERANDO_MONTO: begin
                if (bus.monto_stb) begin
                    w_monto_sig  = bus.monto;
                    w_tipo_sig   = bus.tipo_trans;
                    w_estado_sig = TRANSACCION;
                end
            end
            TRANSACCION: begin
                w_estado_sig = IDLE;
                if (r_tipo == RETIRO) begin
                    if (w_monto_ext <= r_balance) begin
                        w_balance_sig  = r_balance - w_monto_ext;
                        w_entregar_sig = 1'b1;
                    end else begin
                        w_fondos_sig = 1'b1;
                    end
                end else begin
                    w_balance_sig = w_suma[ANCHO_BALANCE] ? '1
                                                          : w_suma[ANCHO_BALANCE-1:0];
                end
            end
            BLOQUEO: begin
                w_bloqueo_sig = 1'b1;
            end
            default: begin
                w_estado_sig = IDLE;
            end
        endcase
    end

    assign bus.balance_actualizado  = r_balance;
    assign bus.entregar_dinero      = r_entregar;
    assign bus.pin_incorrecto       = r_pin_inc;
    assign bus.advertencia          = r_adv;
    assign bus.bloqueo              = r_bloqueo;
    assign bus.fondos_insuficientes = r_fondos;

endmodule
`default_nettype wire

// File: tb/tb_cajero_param.sv
`default_nettype none
// ============================================================================
//  Module      : tb_cajero_param
//  Description : Self-checking bench for cajero_param. Two instances: a
//                4-digit / 32-bit unit and a 6-digit / 8-bit unit, selected
//                by sel. Expected values come from a session-level model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_cajero_param;

    localparam int MAX_I = 3;

    logic clock = 1'b0;
    logic reset;
    always #5 clock = ~clock;

    cajero_param_if #(.N_DIGITOS(4), .ANCHO_BALANCE(32), .ANCHO_MONTO(32)) if_a ();
    cajero_param_if #(.N_DIGITOS(6), .ANCHO_BALANCE(8),  .ANCHO_MONTO(8))  if_b ();

    cajero_param #(.N_DIGITOS(4), .MAX_INTENTOS(MAX_I), .ANCHO_BALANCE(32), .ANCHO_MONTO(32))
        dut_a (.clock(clock), .reset(reset), .bus(if_a));
    cajero_param #(.N_DIGITOS(6), .MAX_INTENTOS(MAX_I), .ANCHO_BALANCE(8), .ANCHO_MONTO(8))
        dut_b (.clock(clock), .reset(reset), .bus(if_b));

    // Shared stimulus, routed to the selected instance.
    int          sel;
    logic        tarjeta, dstb, mstb, tipo;
    logic [3:0]  dig;
    logic [31:0] bal_in, monto;
    logic [23:0] pin_v;

    assign if_a.tarjeta_recibida = tarjeta && (sel == 0);
    assign if_a.digito_stb       = dstb && (sel == 0);
    assign if_a.monto_stb        = mstb && (sel == 0);
    assign if_a.digito           = dig;
    assign if_a.tipo_trans       = tipo;
    assign if_a.balance_entrada  = bal_in;
    assign if_a.monto            = monto;
    assign if_a.pin              = pin_v[15:0];

    assign if_b.tarjeta_recibida = tarjeta && (sel == 1);
    assign if_b.digito_stb       = dstb && (sel == 1);
    assign if_b.monto_stb        = mstb && (sel == 1);
    assign if_b.digito           = dig;
    assign if_b.tipo_trans       = tipo;
    assign if_b.balance_entrada  = bal_in[7:0];
    assign if_b.monto            = monto[7:0];
    assign if_b.pin              = pin_v;

    logic [31:0] o_bal;
    logic        o_ent, o_inc, o_adv, o_blq, o_fon;
    always_comb begin
        if (sel == 0) begin
            o_bal = if_a.balance_actualizado;
            o_ent = if_a.entregar_dinero;
            o_inc = if_a.pin_incorrecto;
            o_adv = if_a.advertencia;
            o_blq = if_a.bloqueo;
            o_fon = if_a.fondos_insuficientes;
        end else begin
            o_bal = {24'd0, if_b.balance_actualizado};
            o_ent = if_b.entregar_dinero;
            o_inc = if_b.pin_incorrecto;
            o_adv = if_b.advertencia;
            o_blq = if_b.bloqueo;
            o_fon = if_b.fondos_insuficientes;
        end
    end

    // Session-level reference model, one slot per instance.
    // fase: 0 = no card, 1 = entering PIN, 2 = awaiting amount
    longint m_bal  [2];
    int     m_int  [2];
    bit     m_adv  [2];
    bit     m_lock [2];
    int     m_fase [2];

    int n_checks = 0;
    int n_errors = 0;

    function automatic int ndig(int s);
        return (s == 0) ? 4 : 6;
    endfunction

    function automatic longint maxbal(int s);
        return (s == 0) ? 64'h0000_0000_FFFF_FFFF : 64'd255;
    endfunction

    function automatic logic [23:0] rand_bcd(int n);
        logic [23:0] v = '0;
        for (int i = 0; i < n; i++) v = (v << 4) | 24'($urandom_range(0, 9));
        return v;
    endfunction

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        tick();
        chk("reset_outputs_a", {if_a.balance_actualizado, if_a.entregar_dinero, if_a.pin_incorrecto,
                                 if_a.advertencia, if_a.bloqueo, if_a.fondos_insuficientes}, 64'd0);
        chk("reset_outputs_b", {if_b.balance_actualizado, if_b.entregar_dinero, if_b.pin_incorrecto,
                                 if_b.advertencia, if_b.bloqueo, if_b.fondos_insuficientes}, 64'd0);
        reset = 1'b0;
        for (int s = 0; s < 2; s++) begin
            m_bal[s] = 0; m_int[s] = 0; m_adv[s] = 0; m_lock[s] = 0; m_fase[s] = 0;
        end
    endtask

    task automatic card(input logic [31:0] b, input logic [23:0] p);
        pin_v   = p;
        bal_in  = b;
        tarjeta = 1'b1;
        tick();
        tarjeta = 1'b0;
        if (!m_lock[sel] && m_fase[sel] == 0) begin
            m_bal[sel]  = longint'(b) & maxbal(sel);
            m_fase[sel] = 1;
        end
        chk("card_balance", o_bal, m_bal[sel]);
        chk("card_bloqueo", o_blq, m_lock[sel]);
    endtask

    // Strobe n digits (first digit from the MS end of the n-digit code),
    // with random monto_stb noise that must be ignored.
    task automatic enter(input logic [23:0] code, input int n);
        logic [23:0] mask;
        bit exp_inc = 0;
        for (int i = 0; i < n; i++) begin
            dig  = code[4*(n-1-i) +: 4];
            dstb = 1'b1;
            mstb = ($urandom_range(0, 3) == 0);
            tick();
            dstb = 1'b0;
            mstb = 1'b0;
        end
        if (n == ndig(sel) && m_fase[sel] == 1 && !m_lock[sel]) begin
            mask = (sel == 0) ? 24'h00FFFF : 24'hFFFFFF;
            if ((code & mask) == (pin_v & mask)) begin
                m_int[sel]  = 0;
                m_adv[sel]  = 0;
                m_fase[sel] = 2;
            end else begin
                m_int[sel]++;
                exp_inc = 1;
                if (m_int[sel] == MAX_I)          m_lock[sel] = 1;
                else if (m_int[sel] == MAX_I - 1) m_adv[sel]  = 1;
            end
        end
        tick();
        chk("pin_incorrecto_pulse", o_inc, exp_inc);
        chk("advertencia", o_adv, m_adv[sel]);
        chk("bloqueo", o_blq, m_lock[sel]);
        tick();
        chk("pin_incorrecto_low", o_inc, 1'b0);
    endtask

    task automatic transact(input bit t, input logic [31:0] m);
        bit exp_ent = 0, exp_fon = 0;
        longint mm;
        tipo = t;
        monto = m;
        mstb = 1'b1;
        dstb = ($urandom_range(0, 3) == 0);
        tick();
        mstb = 1'b0;
        dstb = 1'b0;
        tick();
        if (m_fase[sel] == 2 && !m_lock[sel]) begin
            mm = longint'(m) & maxbal(sel);
            if (t) begin
                if (mm <= m_bal[sel]) begin
                    m_bal[sel] -= mm;
                    exp_ent = 1;
                end else begin
                    exp_fon = 1;
                end
            end else begin
                m_bal[sel] = (m_bal[sel] + mm > maxbal(sel)) ? maxbal(sel) : m_bal[sel] + mm;
            end
            m_fase[sel] = 0;
        end
        chk("entregar_dinero", o_ent, exp_ent);
        chk("fondos_insuficientes", o_fon, exp_fon);
        chk("balance_after", o_bal, m_bal[sel]);
        tick();
        chk("pulses_low", {o_ent, o_fon}, 2'b00);
        chk("balance_hold", o_bal, m_bal[sel]);
    endtask

    initial begin
        logic [23:0] p, w;
        logic [31:0] b, m;
        sel = 0; tarjeta = 0; dstb = 0; mstb = 0; tipo = 0;
        dig = '0; bal_in = '0; monto = '0; pin_v = '0;

        do_reset();

        // Correct PIN, withdrawal.
        card(32'd1000, 24'h1234);
        enter(24'h1234, 4);
        transact(1'b1, 32'd300);
        chk("t1_balance_700", o_bal, 64'd700);

        // Overdraft by one.
        card(32'd100, 24'h1234);
        enter(24'h1234, 4);
        transact(1'b1, 32'd101);
        chk("t2_balance_100", o_bal, 64'd100);

        // Retry and lockout.
        card(32'd500, 24'h4321);
        enter(24'h1111, 4);
        chk("t3_no_warning_yet", o_adv, 1'b0);
        enter(24'h2222, 4);
        chk("t3_warning", o_adv, 1'b1);
        enter(24'h3333, 4);
        chk("t3_locked", o_blq, 1'b1);
        enter(24'h4321, 4);
        transact(1'b0, 32'd50);
        card(32'd9, 24'h4321);
        chk("t3_still_locked", o_blq, 1'b1);
        do_reset();

        // Recovery after one wrong PIN.
        card(32'd800, 24'h5678);
        enter(24'h5670, 4);
        enter(24'h5678, 4);
        chk("t4_warning_clear", o_adv, 1'b0);
        transact(1'b0, 32'd200);
        chk("t4_balance_1000", o_bal, 64'd1000);

        // Warning is only raised on the second consecutive-by-count miss;
        // counter cleared by the recovery above.
        card(32'd10, 24'h0909);
        enter(24'h0000, 4);
        chk("t4b_no_warning", o_adv, 1'b0);
        enter(24'h0909, 4);
        transact(1'b1, 32'd10);
        chk("t4b_balance_0", o_bal, 64'd0);

        // Reset mid-PIN needs a full fresh PIN afterwards.
        card(32'd300, 24'h2468);
        enter(24'h0024, 2);
        do_reset();
        card(32'd300, 24'h2468);
        enter(24'h2468, 4);
        transact(1'b1, 32'd100);
        chk("t5_balance_200", o_bal, 64'd200);

        // 6-digit / 8-bit instance: deposit saturation and reset mid-PIN.
        sel = 1;
        card(32'd250, 24'h135790);
        enter(24'h135790, 6);
        transact(1'b0, 32'd10);
        chk("t6_saturate_255", o_bal, 64'd255);
        card(32'd200, 24'h864209);
        enter(24'h000864, 3);
        do_reset();
        card(32'd200, 24'h864209);
        enter(24'h864209, 6);
        transact(1'b1, 32'd50);
        chk("t7_balance_150", o_bal, 64'd150);
        card(32'd40, 24'h111111);
        enter(24'h111112, 6);
        enter(24'h111111, 6);
        transact(1'b1, 32'd40);

        // Randomised sessions on the 32-bit instance.
        sel = 0;
        for (int k = 0; k < 40; k++) begin
            if (m_lock[0]) do_reset();
            p = rand_bcd(4);
            case ($urandom_range(0, 3))
                0:       b = $urandom_range(0, 2000);
                1:       b = 32'hFFFF_FF00 + $urandom_range(0, 255);
                default: b = $urandom_range(0, 100000);
            endcase
            card(b, p);
            while (m_fase[0] == 1 && !m_lock[0]) begin
                if ($urandom_range(0, 2) == 0) begin
                    do w = rand_bcd(4); while (w == p);
                    enter(w, 4);
                end else begin
                    enter(p, 4);
                end
            end
            if (!m_lock[0]) begin
                case ($urandom_range(0, 3))
                    0:       m = $urandom_range(0, 3000);
                    1:       m = $urandom();
                    2:       m = 32'(m_bal[0]);
                    default: m = 32'(m_bal[0]) + 32'd1;
                endcase
                transact(1'($urandom_range(0, 1)), m);
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
